// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the mod_counter timebase/index counter.
package mod_counter_pkg;

    typedef enum logic {DIR_DOWN, DIR_UP} cnt_dir_e;
    typedef enum logic {MODE_WRAP, MODE_SAT} cnt_mode_e;

    // Limit a requested load value to the highest legal count.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational step logic for mod_counter: next count plus wrap/sat flags.
// The boundary is compared before any add or subtract, so a full-range
// MAX_VAL (2**WIDTH-1) never depends on natural overflow.
module mod_counter_step
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic [WIDTH-1:0] count_i,
    input  cnt_dir_e         dir_i,
    input  cnt_mode_e        mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // One step in the requested direction, wrapping or saturating at the ends.
    always_comb begin
        next_o = count_i;
        wrap_o = 1'b0;
        sat_o  = 1'b0;
        if (dir_i == DIR_UP) begin
            if (count_i == MAX) begin
                if (mode_i == MODE_SAT) begin
                    sat_o = 1'b1;
                end else begin
                    next_o = '0;
                    wrap_o = 1'b1;
                end
            end else begin
                next_o = count_i + ONE;
            end
        end else begin
            if (count_i == '0) begin
                if (mode_i == MODE_SAT) begin
                    sat_o = 1'b1;
                end else begin
                    next_o = MAX;
                    wrap_o = 1'b1;
                end
            end else begin
                next_o = count_i - ONE;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo counter with up/down, enable, load and wrap/saturate.
// Define MOD_COUNTER_ASSERT_EN to compile in the embedded assertions and covers.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MAX_VAL   = 15,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned SAT_MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_term,
    output logic             wrap,
    output logic             sat,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RVAL = WIDTH'(RESET_VAL);
    localparam cnt_mode_e        MODE = (SAT_MODE != 0) ? MODE_SAT : MODE_WRAP;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             lerr_q, lerr_d;

    logic [WIDTH-1:0] step_cnt;
    logic             step_wrap, step_sat;
    cnt_dir_e         dir;

    assign dir = up ? DIR_UP : DIR_DOWN;

    mod_counter_step #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_step (
        .count_i (count_q),
        .dir_i   (dir),
        .mode_i  (MODE),
        .next_o  (step_cnt),
        .wrap_o  (step_wrap),
        .sat_o   (step_sat)
    );

    // Next state: load beats step; pulses default low so they last one cycle.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        lerr_d  = 1'b0;
        if (load) begin
            count_d = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
            lerr_d  = (load_val > MAX);
        end else if (en) begin
            count_d = step_cnt;
            wrap_d  = step_wrap;
            sat_d   = step_sat;
        end
    end

    // Counter and pulse registers; reset overrides load and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RVAL;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
            lerr_q  <= lerr_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign load_err = lerr_q;
    assign at_term  = up ? (count_q == MAX) : (count_q == '0);

`ifdef MOD_COUNTER_ASSERT_EN
    a_range: assert property (@(posedge clk) disable iff (rst) count_q <= MAX);
    a_wrap_end: assert property (@(posedge clk) disable iff (rst)
        wrap_q |-> (count_q == '0 || count_q == MAX));
    a_excl: assert property (@(posedge clk) disable iff (rst) !(wrap_q && sat_q));
    a_sat_nowrap: assert property (@(posedge clk) disable iff (rst)
        (SAT_MODE == 0) || !wrap_q);
    a_ld_clamp: assert property (@(posedge clk) disable iff (rst)
        (load && load_val > MAX) |=> count_q == MAX);

    c_wrap_up: cover property (@(posedge clk) disable iff (rst)
        (en && up && !load && count_q == MAX) ##1 wrap_q);
    c_wrap_dn: cover property (@(posedge clk) disable iff (rst)
        (en && !up && !load && count_q == '0) ##1 wrap_q);
    c_sat: cover property (@(posedge clk) disable iff (rst) sat_q);
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter: three instances (default wrap, saturate,
// and a 4-bit full-range counter). The driver pushes hand-derived expected
// values; a monitor pops and compares one entry after each rising edge.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en = '0, up = '0, ld = '0;
    logic [5:0] lv0 = '0, lv1 = '0;
    logic [3:0] lv2 = '0;
    logic [5:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic [2:0] at, wr, st, le;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(6), .MAX_VAL(15), .RESET_VAL(0), .SAT_MODE(0)) u_d0 (
        .clk(clk), .rst(rst), .en(en[0]), .up(up[0]), .load(ld[0]), .load_val(lv0),
        .count(cnt0), .at_term(at[0]), .wrap(wr[0]), .sat(st[0]), .load_err(le[0]));

    mod_counter #(.WIDTH(6), .MAX_VAL(15), .RESET_VAL(0), .SAT_MODE(1)) u_d1 (
        .clk(clk), .rst(rst), .en(en[1]), .up(up[1]), .load(ld[1]), .load_val(lv1),
        .count(cnt1), .at_term(at[1]), .wrap(wr[1]), .sat(st[1]), .load_err(le[1]));

    mod_counter #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0), .SAT_MODE(0)) u_d2 (
        .clk(clk), .rst(rst), .en(en[2]), .up(up[2]), .load(ld[2]), .load_val(lv2),
        .count(cnt2), .at_term(at[2]), .wrap(wr[2]), .sat(st[2]), .load_err(le[2]));

    typedef struct {
        int         d;
        string      nm;
        logic [5:0] c;
        logic       w, s, l, a;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input string fld, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0d exp=%0d at %0t", nm, fld, got, exp, $time);
        end
    endtask

    // Monitor: compare one expected entry just after every rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [5:0] gc;
            e = sb.pop_front();
            gc = (e.d == 0) ? cnt0 : (e.d == 1) ? cnt1 : {2'b00, cnt2};
            chk(e.nm, "count",    gc,             e.c);
            chk(e.nm, "wrap",     6'(wr[e.d]),    6'(e.w));
            chk(e.nm, "sat",      6'(st[e.d]),    6'(e.s));
            chk(e.nm, "load_err", 6'(le[e.d]),    6'(e.l));
            chk(e.nm, "at_term",  6'(at[e.d]),    6'(e.a));
        end
    end

    // Drive one cycle into instance d and push its expected post-edge state.
    task automatic cyc(input int d, input string nm, input logic r, input logic e,
                       input logic u, input logic l, input logic [5:0] v,
                       input logic [5:0] ec, input logic ew, input logic es,
                       input logic el, input logic ea);
        exp_t x;
        @(negedge clk);
        rst = r;
        en = '0; ld = '0;
        en[d] = e; up[d] = u; ld[d] = l;
        if (d == 0) lv0 = v;
        else if (d == 1) lv1 = v;
        else lv2 = v[3:0];
        x.d = d; x.nm = nm; x.c = ec; x.w = ew; x.s = es; x.l = el; x.a = ea;
        sb.push_back(x);
    endtask

    initial begin
        // Reset state of every instance
        cyc(0, "rst0", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, "rst1", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(2, "rst2", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Up count 20 cycles: 1..15, 0 (wrap), 1..4
        for (int i = 0; i < 20; i++)
            cyc(0, "up_run", 0, 1, 1, 0, 0, 6'((i + 1) % 16), i == 15, 0, 0, ((i + 1) % 16) == 15);

        // Down from reset: 0 -> 15 with wrap, then 14, 13; then hold
        cyc(0, "rst_a",   1, 0, 1, 0, 0, 0,  0, 0, 0, 0);
        cyc(0, "dn_wrap", 0, 1, 0, 0, 0, 15, 1, 0, 0, 0);
        cyc(0, "dn_14",   0, 1, 0, 0, 0, 14, 0, 0, 0, 0);
        cyc(0, "dn_13",   0, 1, 0, 0, 0, 13, 0, 0, 0, 0);
        cyc(0, "hold",    0, 0, 0, 0, 0, 13, 0, 0, 0, 0);

        // Over-range load clamps to MAX, then wraps on the next up step
        cyc(0, "ld_clamp", 0, 0, 1, 1, 40, 15, 0, 0, 1, 1);
        cyc(0, "ld_wrap",  0, 1, 1, 0, 0,  0,  1, 0, 0, 0);
        cyc(0, "hold2",    0, 0, 1, 0, 0,  0,  0, 0, 0, 0);
        cyc(0, "ld_max",   0, 0, 0, 1, 15, 15, 0, 0, 0, 0);
        cyc(0, "ld_16",    0, 0, 0, 1, 16, 15, 0, 0, 1, 0);

        // Load beats enable; direction change; reset mid-count then resume
        cyc(0, "ld_pri",  0, 1, 1, 1, 7, 7, 0, 0, 0, 0);
        cyc(0, "up_8",    0, 1, 1, 0, 0, 8, 0, 0, 0, 0);
        cyc(0, "up_9",    0, 1, 1, 0, 0, 9, 0, 0, 0, 0);
        cyc(0, "dir_dn",  0, 1, 0, 0, 0, 8, 0, 0, 0, 0);
        cyc(0, "dir_up",  0, 1, 1, 0, 0, 9, 0, 0, 0, 0);
        cyc(0, "rst_mid", 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, "resume",  0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

        // Saturating instance: top and bottom boundaries
        cyc(1, "sat_ld",  0, 0, 1, 1, 14, 14, 0, 0, 0, 0);
        cyc(1, "sat_up",  0, 1, 1, 0, 0,  15, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            cyc(1, "sat_hi", 0, 1, 1, 0, 0, 15, 0, 1, 0, 1);
        cyc(1, "sat_ld0", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        cyc(1, "sat_lo",  0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, "sat_rel", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

        // 4-bit full-range counter: exact 15->0 and 0->15 wraps
        cyc(2, "w4_rst", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++)
            cyc(2, "w4_run", 0, 1, 1, 0, 0, 6'((i + 1) % 16), i == 15, 0, 0, ((i + 1) % 16) == 15);
        cyc(2, "w4_dn0",  0, 1, 0, 0, 0, 0,  0, 0, 0, 1);
        cyc(2, "w4_dnw",  0, 1, 0, 0, 0, 15, 1, 0, 0, 0);

        @(negedge clk);
        en = '0; ld = '0;
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
